// File: rtl/cla_pipelined_addsub_if.sv
// Streaming operand/result bundle for the pipelined CLA adder/subtractor.
// master drives operands and out_ready; slave is the adder.
interface cla_pipelined_addsub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/cla_pipelined_addsub.sv
// Pipelined carry-lookahead add/sub: one SLICE-wide CLA per stage, carry registered between stages.
// The whole pipe advances as one unit and freezes while the output beat is stalled.
module cla_pipelined_addsub #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_pipelined_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / SLICE;
    localparam int NGRP   = SLICE / 4;

    // Returns {carry_out, sum}; 4-bit groups with lookahead across group carries.
    function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             c);
        logic [SLICE-1:0] g, p;
        logic [SLICE:0]   cy;
        logic [NGRP:0]    gc;
        logic             gg, pp;
        g     = a & b;
        p     = a ^ b;
        cy    = '0;
        gc    = '0;
        gc[0] = c;
        for (int j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg = g[4*j+i] | (p[4*j+i] & gg);
                pp = pp & p[4*j+i];
            end
            gc[j+1]  = gg | (pp & gc[j]);
            cy[4*j]  = gc[j];
            for (int i = 0; i < 3; i++)
                cy[4*j+i+1] = g[4*j+i] | (p[4*j+i] & cy[4*j+i]);
        end
        cy[SLICE] = gc[NGRP];
        return {cy[SLICE], p ^ cy[SLICE-1:0]};
    endfunction

    logic             r_ov, r_cout, r_ovf, r_zero;
    logic [WIDTH-1:0] r_sum;
    logic             w_stall;

    assign w_stall       = r_ov && !bus.out_ready;
    assign bus.in_ready  = !rst && !w_stall;
    assign bus.out_valid = r_ov;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;

    // r_x starts as A and shifts right one slice per stage, with each resolved
    // sum slice entering at the top; after the last stage it holds the full sum.
    // B shrinks by one slice per stage so only unresolved bits travel forward.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int BW = WIDTH - SLICE * k;
        logic [WIDTH-1:0] w_x, w_xn;
        logic [BW-1:0]    w_b;
        logic             w_c, w_v;
        logic [SLICE:0]   w_r;

        if (k == 0) begin : g_in
            assign w_x = bus.in_a;
            assign w_b = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign w_c = bus.in_cin ^ bus.in_sub;
            assign w_v = bus.in_valid;
        end else begin : g_mid
            assign w_x = g_stg[k-1].g_reg.r_x;
            assign w_b = g_stg[k-1].g_reg.r_b;
            assign w_c = g_stg[k-1].g_reg.r_c;
            assign w_v = g_stg[k-1].g_reg.r_v;
        end

        assign w_r  = cla_slice(w_x[SLICE-1:0], w_b[SLICE-1:0], w_c);
        assign w_xn = WIDTH'({w_r[SLICE-1:0], w_x} >> SLICE);

        if (k < STAGES - 1) begin : g_reg
            logic             r_v, r_c;
            logic [WIDTH-1:0] r_x;
            logic [BW-SLICE-1:0] r_b;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                end else if (!w_stall) begin
                    r_v <= w_v;
                    if (w_v) begin
                        r_x <= w_xn;
                        r_b <= w_b[BW-1:SLICE];
                        r_c <= w_r[SLICE];
                    end
                end
            end
        end else begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ov   <= 1'b0;
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (!w_stall) begin
                    r_ov <= w_v;
                    if (w_v) begin
                        r_sum  <= w_xn;
                        r_cout <= w_r[SLICE];
                        // same-sign operands giving an opposite-sign result == carry-in(MSB) ^ carry-out
                        r_ovf  <= (w_x[SLICE-1] == w_b[SLICE-1]) && (w_r[SLICE-1] != w_x[SLICE-1]);
                        r_zero <= (w_xn == '0);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Directed bench for cla_pipelined_addsub at WIDTH=64, SLICE=16 (latency 4).
module tb_cla_pipelined_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipelined_addsub_if #(.WIDTH(64)) bus ();
    cla_pipelined_addsub #(.WIDTH(64), .SLICE(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] q[$];
    int          sent, rcvd, stalls;
    logic [63:0] held;
    logic        held_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        return a + (sub ? ~b : b) + 64'(cin ^ sub);
    endfunction

    task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input logic [63:0] es,
                          input logic ec, input logic eo, input logic ez);
        bus.in_valid = 1'b1;
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
        chk({tag, "_rdy"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_a = ~a; bus.in_b = ~b; bus.in_cin = ~cin; bus.in_sub = ~sub;
        step();
        step();
        chk({tag, "_early"}, bus.out_valid, 0);
        step();
        chk({tag, "_v"}, bus.out_valid, 1);
        chk({tag, "_sum"}, bus.out_sum, es);
        chk({tag, "_cout"}, bus.out_cout, ec);
        chk({tag, "_ovf"}, bus.out_ovf, eo);
        chk({tag, "_zero"}, bus.out_zero, ez);
        step();
        chk({tag, "_drain"}, bus.out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_sum", bus.out_sum, 0);
        chk("rst_cout", bus.out_cout, 0);
        chk("rst_ovf", bus.out_ovf, 0);
        chk("rst_zero", bus.out_zero, 0);
        chk("rst_inrdy", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_inrdy", bus.in_ready, 1);

        single("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'h0, 1, 0, 1);
        single("sub_neg", 64'd5, 64'd7, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
        single("sub_pos", 64'd7, 64'd5, 0, 1, 64'd2, 1, 0, 0);
        single("sub_borrow", 64'd7, 64'd5, 1, 1, 64'd1, 1, 0, 0);
        single("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'h8000_0000_0000_0000, 0, 1, 0);
        single("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
        single("add_xslice", 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 64'h0000_0001_0000_0000, 0, 0, 0);
        single("add_cin", 64'h1234, 64'h1111, 1, 0, 64'h2346, 0, 0, 0);
        single("sub_eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, 1, 64'h0, 1, 0, 1);

        // back-to-back stream: beat c emerges right after edge c+3
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = (c < 8);
            bus.in_a = {48'(c), 16'hFFFF}; bus.in_b = 64'd1; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
            if (c < 8) chk("strm_inrdy", bus.in_ready, 1);
            step();
            if (c >= 3 && c < 11) begin
                chk("strm_v", bus.out_valid, 1);
                chk("strm_sum", bus.out_sum, 64'(c - 2) << 16);
            end else begin
                chk("strm_idle", bus.out_valid, 0);
            end
        end

        // backpressure mid-stream against a queue model
        sent = 0; rcvd = 0; stalls = 0; held_v = 1'b0; held = '0;
        for (int c = 0; c < 40 && rcvd < 8; c++) begin
            bus.out_ready = !(c >= 6 && c < 11);
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_a = 64'h1111_1111_1111_1111 * 64'(sent + 1);
                bus.in_b = 64'(sent * 3);
                bus.in_sub = sent[0];
                bus.in_cin = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (held_v && bus.out_valid) chk("bp_hold", bus.out_sum, held);
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                chk("bp_inrdy", bus.in_ready, 0);
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_nonempty", 64'(q.size() != 0), 1);
                if (q.size() != 0) chk("bp_sum", bus.out_sum, q.pop_front());
                rcvd++;
            end
            held_v = bus.out_valid && !bus.out_ready;
            held   = bus.out_sum;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_count", 64'(rcvd), 8);
        chk("bp_qempty", 64'(q.size()), 0);
        chk("bp_stalls", 64'(stalls), 5);

        // reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 64'(100 + i); bus.in_b = 64'd1; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        chk("rf_pre", bus.out_valid, 0);
        rst = 1'b1;
        step();
        chk("rf_valid", bus.out_valid, 0);
        chk("rf_sum", bus.out_sum, 0);
        chk("rf_inrdy", bus.in_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rf_stale", bus.out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
